// File: rtl/jtcps2_obj_dma.sv
// CPS2 object table DMA: copies object RAM into the write half of a
// double-buffered frame table during vblank, then swaps halves.
module jtcps2_obj_dma (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblank,
    input  logic        obj_en,
    input  logic        obj_page,
    output logic [12:0] ram_addr,
    output logic        ram_req,
    input  logic        ram_ok,
    input  logic [15:0] ram_data,
    output logic        tbl_we,
    output logic [12:0] tbl_waddr,
    output logic [15:0] tbl_wdata,
    output logic        rd_bank,
    output logic        busy,
    output logic        frame_done,
    output logic        abort
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WR,
        DONE
    } state_t;

    state_t      state;
    logic        vb_q;
    logic        page;
    logic [11:0] cnt;
    logic        y_neg;
    logic        attr_ff;
    logic        vb_rise;
    logic        vb_fall;
    logic        at_attr;
    logic        stop;

    assign vb_rise = vblank & ~vb_q;
    assign vb_fall = ~vblank & vb_q;
    assign at_attr = (cnt[1:0] == 2'd3);
    // the terminator entry is copied in full before stopping
    assign stop    = at_attr & (y_neg | attr_ff | (cnt[11:2] == 10'h3ff));

    // vblank edge detector reference
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vb_q <= 1'b0;
        end else begin
            vb_q <= vblank;
        end
    end

    // copy sequencer: request a word, write it, advance or finish
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            page       <= 1'b0;
            cnt        <= 12'd0;
            y_neg      <= 1'b0;
            attr_ff    <= 1'b0;
            ram_addr   <= 13'd0;
            ram_req    <= 1'b0;
            tbl_we     <= 1'b0;
            tbl_waddr  <= 13'd0;
            tbl_wdata  <= 16'd0;
            rd_bank    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            abort      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (vb_rise && obj_en) begin
                        page     <= obj_page;
                        cnt      <= 12'd0;
                        ram_addr <= {obj_page, 12'd0};
                        ram_req  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (vb_fall) begin
                        // window closed: drop any data arriving now
                        ram_req <= 1'b0;
                        busy    <= 1'b0;
                        abort   <= 1'b1;
                        state   <= IDLE;
                    end else if (ram_ok) begin
                        ram_req   <= 1'b0;
                        tbl_we    <= 1'b1;
                        tbl_wdata <= ram_data;
                        tbl_waddr <= {~rd_bank, cnt};
                        if (cnt[1:0] == 2'd1) begin
                            y_neg <= ram_data[15];
                        end
                        if (cnt[1:0] == 2'd3) begin
                            attr_ff <= (ram_data[15:8] == 8'hff);
                        end
                        state <= WR;
                    end
                end
                WR: begin
                    tbl_we <= 1'b0;
                    if (vb_fall) begin
                        busy  <= 1'b0;
                        abort <= 1'b1;
                        state <= IDLE;
                    end else if (stop) begin
                        rd_bank    <= ~rd_bank;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end else begin
                        cnt      <= cnt + 12'd1;
                        ram_addr <= {page, cnt + 12'd1};
                        ram_req  <= 1'b1;
                        state    <= REQ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtcps2_obj_dma.sv
// Randomized bench for jtcps2_obj_dma against a table-level model
// of which words land where in the frame table.
module tb_jtcps2_obj_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        vblank;
    logic        obj_en;
    logic        obj_page;
    logic [12:0] ram_addr;
    logic        ram_req;
    logic        ram_ok;
    logic [15:0] ram_data;
    logic        tbl_we;
    logic [12:0] tbl_waddr;
    logic [15:0] tbl_wdata;
    logic        rd_bank;
    logic        busy;
    logic        frame_done;
    logic        abort;

    jtcps2_obj_dma dut (
        .clk        (clk),
        .rst        (rst),
        .vblank     (vblank),
        .obj_en     (obj_en),
        .obj_page   (obj_page),
        .ram_addr   (ram_addr),
        .ram_req    (ram_req),
        .ram_ok     (ram_ok),
        .ram_data   (ram_data),
        .tbl_we     (tbl_we),
        .tbl_waddr  (tbl_waddr),
        .tbl_wdata  (tbl_wdata),
        .rd_bank    (rd_bank),
        .busy       (busy),
        .frame_done (frame_done),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [8192];
    logic [28:0] got [$];

    int total = 0;
    int bad = 0;
    int tk = 0;
    int last_we = 0;
    int fd_tk = 0;
    int fd_cnt = 0;
    int ab_cnt = 0;
    int req_cycles = 0;
    int addr_err = 0;
    int swap_bad = 0;
    int wcnt = 0;
    int lat_min = 0;
    int lat_max = 0;
    int issued = 0;
    int kill_n = -1;
    bit killed_last = 0;
    bit post_req = 0;
    bit post_abort = 0;
    bit prev_rd = 0;
    bit exp_rd = 0;
    bit req_at1 = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] adr(bit pg, int e, int w);
        logic [9:0] e10;
        logic [1:0] w2;
        e10 = e[9:0];
        w2  = w[1:0];
        return {pg, e10, w2};
    endfunction

    // random contents with no accidental terminators
    task automatic fill_mem();
        for (int i = 0; i < 8192; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (i % 4 == 1) w[15] = 1'b0;
            if (i % 4 == 3 && w[15:8] == 8'hff) w[15:8] = 8'h7f;
            mem[i] = w;
        end
    endtask

    // number of words a frame copies from page pg
    function automatic int model_words(bit pg);
        for (int e = 0; e < 1024; e++) begin
            logic [15:0] y;
            logic [15:0] a;
            y = mem[adr(pg, e, 1)];
            a = mem[adr(pg, e, 3)];
            if (y[15] || a[15:8] == 8'hff) return (e + 1) * 4;
        end
        return 4096;
    endfunction

    // one cycle: observe outputs at negedge, then act as object RAM
    task automatic tick();
        @(negedge clk);
        tk++;
        if (tbl_we) begin
            got.push_back({tbl_waddr, tbl_wdata});
            last_we = tk;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_tk = tk;
            if (rd_bank == prev_rd) swap_bad++;
        end
        if (abort) ab_cnt++;
        if (ram_req) begin
            req_cycles++;
            if (ram_addr[12] !== obj_page) addr_err++;
        end
        if (killed_last) begin
            post_req = ram_req;
            post_abort = abort;
            killed_last = 0;
        end
        prev_rd = rd_bank;
        if (ram_ok) begin
            ram_ok = 1'b0;
        end else if (ram_req) begin
            if (wcnt <= 0) begin
                ram_ok = 1'b1;
                ram_data = mem[ram_addr];
                issued++;
                wcnt = $urandom_range(lat_max, lat_min);
                if (kill_n >= 0 && issued == kill_n + 1) begin
                    vblank = 1'b0;
                    killed_last = 1;
                    kill_n = -1;
                end
            end else begin
                wcnt--;
            end
        end
    endtask

    task automatic run_frame(bit pg, int budget);
        int n;
        obj_en = 1'b1;
        obj_page = pg;
        fd_cnt = 0;
        ab_cnt = 0;
        req_cycles = 0;
        addr_err = 0;
        swap_bad = 0;
        issued = 0;
        got.delete();
        vblank = 1'b1;
        tick();
        req_at1 = ram_req;
        n = 1;
        while (fd_cnt == 0 && ab_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("timeout", (n >= budget) ? 1 : 0, 0);
        vblank = 1'b0;
        repeat (3) tick();
    endtask

    task automatic verify(string tag, bit pg, bit bank, int n);
        int nb;
        nb = 0;
        chk({tag, "_len"}, got.size(), n);
        for (int k = 0; k < got.size(); k++) begin
            logic [11:0] w12;
            logic [12:0] a;
            w12 = k[11:0];
            a = {pg, w12};
            if (k < n && got[k] !== {bank, w12, mem[a]}) nb++;
        end
        chk({tag, "_data"}, nb, 0);
    endtask

    initial begin
        int n;
        int e;
        bit pg;
        rst = 1'b1;
        vblank = 1'b0;
        obj_en = 1'b0;
        obj_page = 1'b0;
        ram_ok = 1'b0;
        ram_data = 16'd0;
        repeat (3) tick();
        chk("rst_ctl", {ram_req, tbl_we, busy, frame_done, abort, rd_bank}, 0);
        chk("rst_addr", {ram_addr, tbl_waddr}, 0);
        chk("rst_wdata", tbl_wdata, 0);
        rst = 1'b0;
        repeat (2) tick();

        // full table, fixed one-cycle wait
        fill_mem();
        lat_min = 1;
        lat_max = 1;
        run_frame(0, 20000);
        chk("full_reqlat", req_at1, 1);
        verify("full", 0, 1, 4096);
        chk("full_fd", fd_cnt, 1);
        chk("full_fdlat", fd_tk - last_we, 1);
        chk("full_swapcyc", swap_bad, 0);
        exp_rd = ~exp_rd;
        chk("full_bank", rd_bank, exp_rd);

        // y terminator at entry 5, page 1
        fill_mem();
        mem[adr(1, 5, 1)] = 16'h8000;
        lat_min = 0;
        lat_max = 3;
        run_frame(1, 5000);
        verify("yterm", 1, ~exp_rd, 24);
        chk("yterm_page", addr_err, 0);
        chk("yterm_fd", fd_cnt, 1);
        exp_rd = ~exp_rd;
        chk("yterm_bank", rd_bank, exp_rd);

        // attr terminator at entry 0
        fill_mem();
        mem[adr(0, 0, 3)] = 16'hff00;
        run_frame(0, 5000);
        verify("aterm", 0, ~exp_rd, 4);
        exp_rd = ~exp_rd;
        chk("aterm_bank", rd_bank, exp_rd);

        // random pages and terminators
        for (int r = 0; r < 2; r++) begin
            fill_mem();
            pg = 1'($urandom_range(1, 0));
            e = $urandom_range(150, 0);
            if ($urandom_range(1, 0) == 1)
                mem[adr(pg, e, 1)][15] = 1'b1;
            else
                mem[adr(pg, e, 3)][15:8] = 8'hff;
            n = model_words(pg);
            run_frame(pg, 8000);
            verify("rand", pg, ~exp_rd, n);
            chk("rand_page", addr_err, 0);
            exp_rd = ~exp_rd;
            chk("rand_bank", rd_bank, exp_rd);
        end

        // abort with ram_ok on the falling-edge cycle
        fill_mem();
        mem[adr(0, 500, 1)] = 16'h8000;
        lat_min = 0;
        lat_max = 2;
        kill_n = 100;
        run_frame(0, 8000);
        verify("abort", 0, ~exp_rd, 100);
        chk("abort_pulse", ab_cnt, 1);
        chk("abort_nofd", fd_cnt, 0);
        chk("abort_bank", rd_bank, exp_rd);
        chk("abort_req", post_req, 0);
        chk("abort_lat", post_abort, 1);
        chk("abort_busy", busy, 0);

        // obj_en low: the rising edge is ignored
        obj_en = 1'b0;
        req_cycles = 0;
        got.delete();
        vblank = 1'b1;
        repeat (20) tick();
        chk("dis_req", req_cycles, 0);
        chk("dis_wr", got.size(), 0);
        chk("dis_busy", busy, 0);
        vblank = 1'b0;
        repeat (3) tick();

        // asynchronous reset in the middle of a copy
        fill_mem();
        mem[adr(0, 40, 1)] = 16'h8000;
        obj_en = 1'b1;
        obj_page = 1'b0;
        vblank = 1'b1;
        repeat (60) tick();
        chk("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctl", {ram_req, tbl_we, busy, frame_done, abort, rd_bank}, 0);
        chk("arst_addr", {ram_addr, tbl_waddr}, 0);
        vblank = 1'b0;
        ram_ok = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        exp_rd = 0;
        repeat (2) tick();
        run_frame(0, 5000);
        verify("post_rst", 0, 1, 164);
        exp_rd = ~exp_rd;
        chk("post_rst_bank", rd_bank, exp_rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
